// File: rtl/umi_regbank_pkg.sv
// Shared definitions for the umi_regbank register bank.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package umi_regbank_pkg;

  // Default geometry of the bank
  localparam int DEF_AW     = 64;
  localparam int DEF_RW     = 64;
  localparam int DEF_NREG   = 16;

  // Interrupt register pair: W1C status followed by its enable
  localparam int IRQ_STATUS_IDX = 14;
  localparam int IRQ_ENABLE_IDX = IRQ_STATUS_IDX + 1;

  // Access sizes wider than the register collapse to a full-word access.
  function automatic logic [2:0] clamp_size(input logic [2:0] size, input int unsigned bw);
    clamp_size = (32'(size) > bw) ? 3'(bw) : size;
  endfunction

endpackage

// File: rtl/umi_regbank_wstrb.sv
// Converts (byte offset, log2 size, right-aligned data) into byte strobes and lane-aligned data.
// Latency: purely combinational.
// Backpressure: none; every input pattern yields a result.
// Ports: off/size/wrdata in; strb (one bit per byte lane) and data (lane-aligned) out.
module umi_regbank_wstrb
  import umi_regbank_pkg::*;
#(
  parameter int RW = 64,
  localparam int NB = RW / 8,
  localparam int BW = $clog2(NB)
) (
  input  logic [BW-1:0] off,
  input  logic [2:0]    size,
  input  logic [RW-1:0] wrdata,
  output logic [NB-1:0] strb,
  output logic [RW-1:0] data
);

  logic          big;
  logic [2:0]    sz;
  logic [BW-1:0] eoff;

  always_comb begin
    big  = 32'(size) > BW;
    sz   = clamp_size(size, BW);
    // Oversized accesses are full-word, so they always start at lane 0
    eoff = big ? '0 : off;
    strb = '0;
    for (int b = 0; b < NB; b++) begin
      // Lanes past the top of the word are dropped, never wrapped
      strb[b] = (b >= int'(eoff)) && (b < int'(eoff) + (1 << sz));
    end
    // Lane b receives source byte (b - off)
    data = wrdata << {eoff, 3'b000};
  end

endmodule

// File: rtl/umi_regbank.sv
// Register bank behind umi_regif: RW control regs, RO hw status regs, W1C irq status/enable.
// Latency: writes land at the next edge; read data is registered, valid the cycle after reg_read.
// Backpressure: none; every access completes in one cycle, writes to RO registers are dropped.
// Ports: clk/nreset; reg_addr/reg_write/reg_read/reg_size/reg_wrdata access in; reg_rddata out;
//        hw_status/hw_event hardware inputs; reg_out full register view; irq registered interrupt.
module umi_regbank
  import umi_regbank_pkg::*;
#(
  parameter int              AW     = DEF_AW,
  parameter int              RW     = DEF_RW,
  parameter int              NREG   = DEF_NREG,
  parameter logic [NREG-1:0] ROMASK = 16'h000C,
  parameter int              IRQIDX = IRQ_STATUS_IDX
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic [AW-1:0]        reg_addr,
  input  logic                 reg_write,
  input  logic                 reg_read,
  input  logic [2:0]           reg_size,
  input  logic [RW-1:0]        reg_wrdata,
  output logic [RW-1:0]        reg_rddata,
  input  logic [NREG*RW-1:0]   hw_status,
  input  logic [RW-1:0]        hw_event,
  output logic [NREG*RW-1:0]   reg_out,
  output logic                 irq
);

  localparam int NB = RW / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(NREG);

  logic [IW-1:0] idx;
  logic [BW-1:0] off;
  logic [NB-1:0] strb;
  logic [RW-1:0] wdata;
  logic [RW-1:0] bmask;
  logic [RW-1:0] cur [NREG];
  logic [RW-1:0] nxt [NREG];

  assign idx = reg_addr[BW +: IW];
  assign off = reg_addr[BW-1:0];

  // Upper address bits are matched upstream
  logic unused_addr;
  assign unused_addr = ^reg_addr[AW-1:BW+IW];

  umi_regbank_wstrb #(.RW(RW)) u_wstrb (
    .off    (off),
    .size   (reg_size),
    .wrdata (reg_wrdata),
    .strb   (strb),
    .data   (wdata)
  );

  always_comb begin
    bmask = '0;
    for (int b = 0; b < NB; b++) bmask[b*8 +: 8] = {8{strb[b]}};
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    logic hit;
    assign hit = reg_write && (idx == IW'(i));

    if (ROMASK[i]) begin : g_ro
      assign cur[i] = hw_status[i*RW +: RW];
      assign nxt[i] = cur[i];
      logic unused_hit;
      assign unused_hit = hit;
    end else begin : g_rw
      logic [RW-1:0] q;
      logic unused_hw;
      assign unused_hw = ^hw_status[i*RW +: RW];

      if (i == IRQIDX) begin : g_w1c
        // Clear first, then OR in events so a same-cycle event wins over the clear
        assign nxt[i] = (q & ~(hit ? (wdata & bmask) : '0)) | hw_event;
      end else begin : g_plain
        assign nxt[i] = hit ? ((q & ~bmask) | (wdata & bmask)) : q;
      end

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) q <= '0;
        else         q <= nxt[i];
      end
      assign cur[i] = q;
    end

    assign reg_out[i*RW +: RW] = cur[i];
  end

  // Read returns pre-write values; data holds until the next read
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)       reg_rddata <= '0;
    else if (reg_read) reg_rddata <= cur[idx];
  end

  // Built from the post-update values so irq trails hw_event by one edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) irq <= 1'b0;
    else         irq <= |(nxt[IRQIDX] & nxt[IRQIDX+1]);
  end

endmodule

// File: tb/tb_umi_regbank.sv
// Bench for umi_regbank: directed accesses, read expectations scoreboarded and checked by a monitor.
module tb_umi_regbank;
  localparam int AW   = 64;
  localparam int RW   = 64;
  localparam int NREG = 16;

  logic                 clk = 1'b0;
  logic                 nreset;
  logic [AW-1:0]        reg_addr;
  logic                 reg_write;
  logic                 reg_read;
  logic [2:0]           reg_size;
  logic [RW-1:0]        reg_wrdata;
  logic [RW-1:0]        reg_rddata;
  logic [NREG*RW-1:0]   hw_status;
  logic [RW-1:0]        hw_event;
  logic [NREG*RW-1:0]   reg_out;
  logic                 irq;

  umi_regbank dut (
    .clk        (clk),
    .nreset     (nreset),
    .reg_addr   (reg_addr),
    .reg_write  (reg_write),
    .reg_read   (reg_read),
    .reg_size   (reg_size),
    .reg_wrdata (reg_wrdata),
    .reg_rddata (reg_rddata),
    .hw_status  (hw_status),
    .hw_event   (hw_event),
    .reg_out    (reg_out),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [RW-1:0] exp_q[$];
  logic          rd_pend;

  // A read issued at an edge produces data that must be checked after that edge
  always @(posedge clk or negedge nreset) begin
    if (!nreset) rd_pend <= 1'b0;
    else         rd_pend <= reg_read;
  end

  // Monitor: pops one expectation per completed read
  always @(negedge clk) begin
    if (rd_pend) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %h, no expectation queued", reg_rddata);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if (reg_rddata !== e) begin
          n_fail++;
          $display("FAIL rddata: got %h, expected %h", reg_rddata, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [NREG*RW-1:0] act, input logic [NREG*RW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One access cycle; inputs driven just after an edge and sampled at the next one
  task automatic access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [2:0] size, input logic [RW-1:0] data, input logic [RW-1:0] exp);
    reg_read   = rd;
    reg_write  = wr;
    reg_addr   = addr;
    reg_size   = size;
    reg_wrdata = data;
    if (rd) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    reg_read  = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [RW-1:0] exp);
    access(1'b1, 1'b0, addr, 3'd3, '0, exp);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [2:0] size, input logic [RW-1:0] data);
    access(1'b0, 1'b1, addr, size, data, '0);
  endtask

  logic [NREG*RW-1:0] exp_out;

  initial begin
    nreset     = 1'b0;
    reg_addr   = '0;
    reg_write  = 1'b0;
    reg_read   = 1'b0;
    reg_size   = '0;
    reg_wrdata = '0;
    hw_status  = '0;
    hw_event   = '0;

    #12;
    check("reset_rddata", NREG*RW'(reg_rddata), '0);
    check("reset_irq", NREG*RW'(irq), '0);
    check("reset_reg_out", reg_out, '0);

    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Every register reads zero after reset
    for (int i = 0; i < NREG; i++) rd(64'(i * 8), '0);

    // Full-word write then byte write into idx 4
    wr(64'h20, 3'd3, 64'h1122334455667788);
    rd(64'h20, 64'h1122334455667788);
    wr(64'h22, 3'd0, 64'h00000000000000AA);
    rd(64'h20, 64'h1122334455AA7788);
    // Halfword at the top byte: upper byte falls off the word
    wr(64'h27, 3'd1, 64'h0000000000001234);
    rd(64'h20, 64'h3422334455AA7788);
    check("reg_out_idx4", NREG*RW'(reg_out[4*RW +: RW]), NREG*RW'(64'h3422334455AA7788));

    // Word write at offset 4 of idx 5, then oversized access forced to full word
    wr(64'h2C, 3'd2, 64'h00000000CAFEBABE);
    rd(64'h28, 64'hCAFEBABE00000000);
    wr(64'h2B, 3'd5, 64'hFFFF000000000001);
    rd(64'h28, 64'hFFFF000000000001);

    // Read-only register ignores writes and mirrors hw_status
    hw_status[2*RW +: RW] = 64'hDEAD;
    wr(64'h10, 3'd3, 64'h0);
    rd(64'h10, 64'hDEAD);
    check("reg_out_ro2", NREG*RW'(reg_out[2*RW +: RW]), NREG*RW'(64'hDEAD));

    // Interrupt: enable bit 0, pulse events 0 and 2
    wr(64'h78, 3'd3, 64'h1);
    check("irq_before_event", NREG*RW'(irq), '0);
    hw_event = 64'h5;
    @(posedge clk);
    #1;
    hw_event = '0;
    check("irq_status_set", NREG*RW'(reg_out[14*RW +: RW]), NREG*RW'(64'h5));
    check("irq_asserted", NREG*RW'(irq), NREG*RW'(1'b1));
    rd(64'h70, 64'h5);

    // W1C bit 0 clears status bit 0 and drops irq
    wr(64'h70, 3'd3, 64'h1);
    check("w1c_status", NREG*RW'(reg_out[14*RW +: RW]), NREG*RW'(64'h4));
    check("w1c_irq", NREG*RW'(irq), '0);

    // Same-cycle event and clear of bit 0: the event wins
    hw_event = 64'h1;
    wr(64'h70, 3'd3, 64'h1);
    hw_event = '0;
    check("set_wins_status", NREG*RW'(reg_out[14*RW +: RW]), NREG*RW'(64'h5));
    check("set_wins_irq", NREG*RW'(irq), NREG*RW'(1'b1));

    // Overlapping read and write: read sees the old value
    wr(64'h20, 3'd3, 64'h5);
    access(1'b1, 1'b1, 64'h20, 3'd3, 64'h9, 64'h5);
    rd(64'h20, 64'h9);

    // Read data holds while no read is issued
    repeat (3) @(posedge clk);
    #1;
    check("rddata_hold", NREG*RW'(reg_rddata), NREG*RW'(64'h9));

    // Asynchronous reset in the middle of a write
    reg_write  = 1'b1;
    reg_addr   = 64'h0;
    reg_size   = 3'd3;
    reg_wrdata = 64'hFF;
    #2;
    nreset = 1'b0;
    #1;
    exp_out = '0;
    exp_out[2*RW +: RW] = 64'hDEAD;
    check("arst_rddata", NREG*RW'(reg_rddata), '0);
    check("arst_irq", NREG*RW'(irq), '0);
    check("arst_reg_out", reg_out, exp_out);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    rd(64'h0, 64'h0);
    rd(64'h20, 64'h0);
    rd(64'h70, 64'h0);

    // Let the monitor drain the last read, then confirm nothing is outstanding
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", NREG*RW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
